// File: rtl/plusmaze_log_pkg.sv
// Shared definitions for the prox event logger: record type codes, field
// widths, the overflow marker word and the writer FSM state encoding.
package plusmaze_log_pkg;

    localparam int TS_BITS  = 28;
    localparam int IDX_BITS = 2;

    localparam logic [1:0] TYPE_RISE = 2'b00;
    localparam logic [1:0] TYPE_FALL = 2'b01;
    localparam logic [1:0] TYPE_OVF  = 2'b10;

    localparam logic [15:0] MARKER_HI = {TYPE_OVF, 14'h0000};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_HI = 2'd1,
        ST_WR_LO = 2'd2
    } log_state_t;

    // High record word: type, sensor index and the top timestamp bits.
    function automatic logic [15:0] make_hi(
        input logic [1:0]            typ,
        input logic [IDX_BITS-1:0]   idx,
        input logic [TS_BITS-17:0]   ts_top
    );
        return {typ, idx, ts_top};
    endfunction

endpackage

// File: rtl/log_fifo.sv
// Single-clock 16-bit show-ahead FIFO with occupancy count and synchronous
// clear. rd_data reads as zero while empty.
module log_fifo #(
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    input  logic                   rd_en,
    output logic [15:0]            rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign rd_valid = (fill != '0);
    assign full     = (fill == (AW+1)'(DEPTH));
    assign do_rd    = rd_en && rd_valid && !clear;
    assign do_wr    = wr_en && !clear && (!full || do_rd);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 16'h0000;

    // Storage array, no reset needed: output is gated by rd_valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally modulo DEPTH; fill tracks push/pop balance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/prox_event_logger.sv
// Timestamps prox-sensor edges against the miniscope frame counter and
// queues two-word records in a local FIFO for the PC to read back.
// Optional macro PROX_LOG_FALL_EN also logs falling edges (type 01).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | pick next record (marker first) or discard if no room
// ST_WR_HI | push the high word of the latched record
// ST_WR_LO | push the low word, then back to ST_IDLE
module prox_event_logger
    import plusmaze_log_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int N_SENSORS  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [N_SENSORS-1:0]        prox,
    input  logic [31:0]                 frame_count,
    input  logic                        rd_en,
    output logic [15:0]                 rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fill_words,
    output logic [15:0]                 drop_count,
    output logic                        overflow
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
`ifdef PROX_LOG_FALL_EN
    localparam int N_SRC = 2 * N_SENSORS;
`else
    localparam int N_SRC = N_SENSORS;
`endif
    localparam int SW = $clog2(N_SRC);

    log_state_t         state, state_n;
    logic [N_SENSORS-1:0] prev;
    logic [N_SRC-1:0]   pend, edge_det, take_vec, coalesce;
    logic [TS_BITS-1:0] ts [N_SRC];
    logic [15:0]        rec_hi, rec_lo, rec_hi_n, rec_lo_n;
    logic [15:0]        wr_data;
    logic               wr_en, take, discard, ovf_clr, ovf_pend;
    logic [SW-1:0]      sel_idx;
    logic               any_pend;
    logic [1:0]         sel_type;
    logic [FW:0]        free_words;
    logic               room;
    logic [3:0]         drop_inc;
    logic [16:0]        drop_sum;
    logic               unused_fc;

    // Top frame-counter bits are not logged; the PC unwraps them.
    assign unused_fc = ^frame_count[31:TS_BITS];

    // Edge detection; nothing registers while disabled or flushing.
    always_comb begin
        edge_det = '0;
        if (enable && !clear) begin
`ifdef PROX_LOG_FALL_EN
            edge_det = {~prox & prev, prox & ~prev};
`else
            edge_det = prox & ~prev;
`endif
        end
    end

    // Lowest-index pending source wins (rises before falls when enabled).
    always_comb begin
        sel_idx  = '0;
        any_pend = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx  = SW'(i);
                any_pend = 1'b1;
            end
        end
`ifdef PROX_LOG_FALL_EN
        sel_type = sel_idx[SW-1] ? TYPE_FALL : TYPE_RISE;
`else
        sel_type = TYPE_RISE;
`endif
    end

    // A pop in the same cycle frees a slot, so count it toward room.
    always_comb begin
        free_words = (FW+1)'(FIFO_DEPTH) - (FW+1)'(fill_words)
                     + (FW+1)'(rd_en & rd_valid);
        room       = (free_words >= (FW+1)'(2));
        take_vec   = take ? (N_SRC'(1) << sel_idx) : '0;
        coalesce   = edge_det & pend & ~take_vec;
        drop_inc   = 4'(discard);
        for (int i = 0; i < N_SRC; i++) drop_inc = drop_inc + 4'(coalesce[i]);
        drop_sum   = {1'b0, drop_count} + 17'(drop_inc);
    end

    // Writer FSM next-state and record selection.
    always_comb begin
        state_n  = state;
        take     = 1'b0;
        discard  = 1'b0;
        ovf_clr  = 1'b0;
        rec_hi_n = rec_hi;
        rec_lo_n = rec_lo;
        wr_en    = 1'b0;
        wr_data  = rec_hi;
        unique case (state)
            ST_IDLE: begin
                if (ovf_pend && room) begin
                    rec_hi_n = MARKER_HI;
                    rec_lo_n = drop_count;
                    ovf_clr  = 1'b1;
                    state_n  = ST_WR_HI;
                end else if (any_pend) begin
                    take = 1'b1;
                    if (room) begin
                        rec_hi_n = make_hi(sel_type, sel_idx[IDX_BITS-1:0],
                                           ts[sel_idx][TS_BITS-1:16]);
                        rec_lo_n = ts[sel_idx][15:0];
                        state_n  = ST_WR_HI;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            ST_WR_HI: begin
                wr_en   = 1'b1;
                wr_data = rec_hi;
                state_n = ST_WR_LO;
            end
            ST_WR_LO: begin
                wr_en   = 1'b1;
                wr_data = rec_lo;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Prox history, pending bits and timestamp of the first uncoalesced edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            pend <= '0;
            for (int i = 0; i < N_SRC; i++) ts[i] <= '0;
        end else begin
            prev <= prox;
            pend <= clear ? '0 : ((pend & ~take_vec) | edge_det);
            for (int i = 0; i < N_SRC; i++) begin
                if (edge_det[i] && !coalesce[i]) ts[i] <= frame_count[TS_BITS-1:0];
            end
        end
    end

    // FSM state, latched record and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rec_hi     <= '0;
            rec_lo     <= '0;
            ovf_pend   <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            state      <= ST_IDLE;
            ovf_pend   <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state  <= state_n;
            rec_hi <= rec_hi_n;
            rec_lo <= rec_lo_n;
            if (discard)      ovf_pend <= 1'b1;
            else if (ovf_clr) ovf_pend <= 1'b0;
            if (drop_inc != 4'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    log_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .fill     (fill_words)
    );

endmodule
